// File: rtl/req_res_pkg.sv
// req_res_pkg: definitions shared by the request/response capture block.
//   - state_e           : handshake FSM states
//   - BUS_ADDR_W/DATA_W : Avalon-MM slave geometry
//   - ADDR_*            : register word addresses
//   - STATUS_*_BIT      : bit positions inside the status register
package req_res_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_EOF = 2'd1,
    DONE     = 2'd2
  } state_e;

  localparam int BUS_ADDR_W = 2;
  localparam int BUS_DATA_W = 32;

  localparam logic [BUS_ADDR_W-1:0] ADDR_RESULT = 2'd0;
  localparam logic [BUS_ADDR_W-1:0] ADDR_STATUS = 2'd1;
  localparam logic [BUS_ADDR_W-1:0] ADDR_SEQ    = 2'd2;

  localparam int STATUS_DONE_BIT    = 0;
  localparam int STATUS_BUSY_BIT    = 1;
  localparam int STATUS_TIMEOUT_BIT = 2;

endpackage

// File: rtl/req_res_capture_if.sv
// req_res_capture_if: read-only Avalon-MM slave bus of the capture block.
//   address    : word address (master -> slave)
//   chipselect : slave select (master -> slave)
//   read_n     : active-low read strobe (master -> slave)
//   readdata   : read data, zero latency (slave -> master)
interface req_res_capture_if;
  import req_res_pkg::*;

  logic [BUS_ADDR_W-1:0] address;
  logic                  chipselect;
  logic                  read_n;
  logic [BUS_DATA_W-1:0] readdata;

  modport master (output address, output chipselect, output read_n, input readdata);
  modport slave  (input address, input chipselect, input read_n, output readdata);

endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: STAGES-deep synchroniser for an asynchronous level, followed
// by one history flop used for edge detection.
//   clk, reset_n : clock, asynchronous active-low reset
//   async_in     : level from another clock domain
//   level        : synchronised level (last synchroniser stage)
//   rise, fall   : one-cycle pulses on level transitions
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/req_res_capture.sv
// req_res_capture: four-phase request/acknowledge with software. A rising
// request level arms a capture of fish_count at the next frame_end; the
// result, a status word and a capture sequence number are readable over a
// read-only Avalon-MM slave. irq is high while a completed result awaits the
// request being dropped.
//   clk, reset_n : clock, asynchronous active-low reset
//   req_level    : request level from the HPS PIO (asynchronous)
//   frame_end    : one-cycle end-of-frame pulse
//   fish_count   : running count, valid in the frame_end cycle
//   bus          : Avalon-MM slave (address/chipselect/read_n/readdata)
//   irq          : level interrupt, high in DONE
module req_res_capture
  import req_res_pkg::*;
#(
  parameter int COUNT_W        = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_level,
  input  logic               frame_end,
  input  logic [COUNT_W-1:0] fish_count,
  req_res_capture_if.slave   bus,
  output logic               irq
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic req_s, req_rise, req_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (req_level),
    .level    (req_s),
    .rise     (req_rise),
    .fall     (req_fall)
  );

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [COUNT_W-1:0]   result_q, result_d;
  logic [7:0]           seq_q, seq_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic                 irq_q, irq_d;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    result_d  = result_q;
    seq_d     = seq_q;
    done_d    = done_q;
    busy_d    = busy_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        if (req_rise) begin
          state_d   = WAIT_EOF;
          timer_d   = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      WAIT_EOF: begin
        if (frame_end) begin
          result_d = fish_count;
          seq_d    = seq_q + 8'd1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end else if (req_fall) begin
          // WAIT_EOF is entered the cycle after a rise and always left on the
          // first cycle req_s is low, so the fall pulse is exactly "req_s = 0".
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      DONE: begin
        // Level, not edge: the request may already have dropped while the
        // capture was being taken.
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    irq_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      result_q  <= '0;
      seq_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      result_q  <= result_d;
      seq_q     <= seq_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  // Zero-latency read mux; data is driven only during an active read.
  logic [BUS_DATA_W-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (bus.chipselect && !bus.read_n) begin
      case (bus.address)
        ADDR_RESULT: rdata = BUS_DATA_W'(result_q);
        ADDR_STATUS: begin
          rdata[STATUS_DONE_BIT]    = done_q;
          rdata[STATUS_BUSY_BIT]    = busy_q;
          rdata[STATUS_TIMEOUT_BIT] = timeout_q;
        end
        ADDR_SEQ:    rdata = {24'b0, seq_q};
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.readdata = rdata;

endmodule

// File: tb/tb_req_res_capture.sv
// Randomised transaction bench for req_res_capture. Each transaction raises
// the request at cycle 0, drops it at cycle r and optionally pulses frame_end
// at cycle fe; the outcome (capture / timeout / abort) and its timing are
// derived arithmetically from those two numbers.
module tb_req_res_capture;
  import req_res_pkg::*;

  localparam int CW = 16;
  localparam int T  = 100;
  localparam int SS = 2;
  localparam int LAT = SS + 1;  // request edge to visible state change

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_level = 1'b0;
  logic          frame_end = 1'b0;
  logic [CW-1:0] fish_count = '0;
  logic          irq;

  req_res_capture_if bus_if();

  req_res_capture #(
    .COUNT_W        (CW),
    .TIMEOUT_CYCLES (T),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_level  (req_level),
    .frame_end  (frame_end),
    .fish_count (fish_count),
    .bus        (bus_if),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // reference state visible through the register map
  logic [CW-1:0] m_result;
  logic [7:0]    m_seq;
  logic          m_done;
  logic          m_timeout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input logic d, input logic b, input logic t);
    return {29'b0, t, b, d};
  endfunction

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.read_n     = 1'b0;
    #1;
    d = bus_if.readdata;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    bus_read(ADDR_RESULT, d); check({tag, "_result"}, d, 32'(m_result));
    bus_read(ADDR_STATUS, d); check({tag, "_status"}, d, status_word(m_done, 1'b0, m_timeout));
    bus_read(ADDR_SEQ, d);    check({tag, "_seq"}, d, {24'b0, m_seq});
    bus_read(2'd3, d);        check({tag, "_addr3"}, d, 32'h0);
  endtask

  // r: cycle req_level goes low; fe: frame_end cycle (-1 none);
  // fe_val: forced count at fe (-1 random)
  task automatic run_txn(input int r, input int fe, input int fe_val);
    bit            cap, tmo;
    int            endc, irq_end, last_c;
    logic [CW-1:0] cap_val;
    logic [31:0]   st_exp;
    logic          irq_exp;
    string         outcome;

    cap     = (fe >= LAT) && (fe <= T + LAT - 1) && (fe <= r + SS);
    tmo     = !cap && (r >= T);
    endc    = cap ? fe + 1 : (tmo ? T + LAT : r + LAT);
    irq_end = (r + LAT > endc + 1) ? r + LAT : endc + 1;
    last_c  = r;
    if (endc > last_c) last_c = endc;
    if (fe > last_c)   last_c = fe;
    last_c  = last_c + 6;
    cap_val = '0;

    @(posedge clk); #1;
    for (int c = 0; c <= last_c; c++) begin
      req_level  = (c < r);
      frame_end  = (c == fe);
      fish_count = CW'($urandom);
      if (c == fe && fe_val >= 0) fish_count = CW'(fe_val);
      if (c == fe) cap_val = fish_count;
      bus_if.address    = ADDR_STATUS;
      bus_if.chipselect = 1'b1;
      bus_if.read_n     = 1'b0;
      @(negedge clk);
      if (c < LAT) begin
        st_exp  = status_word(m_done, 1'b0, m_timeout);
        irq_exp = 1'b0;
      end else if (c < endc) begin
        st_exp  = status_word(1'b0, 1'b1, 1'b0);
        irq_exp = 1'b0;
      end else if (cap || tmo) begin
        st_exp  = status_word(1'b1, 1'b0, tmo);
        irq_exp = (c < irq_end);
      end else begin
        st_exp  = 32'h0;
        irq_exp = 1'b0;
      end
      check("irq", {31'b0, irq}, {31'b0, irq_exp});
      check("status", bus_if.readdata, st_exp);
      @(posedge clk); #1;
    end
    frame_end = 1'b0;

    if (cap) begin
      m_result  = cap_val;
      m_seq     = m_seq + 8'd1;
      m_done    = 1'b1;
      m_timeout = 1'b0;
      outcome   = "capture";
    end else if (tmo) begin
      m_done    = 1'b1;
      m_timeout = 1'b1;
      outcome   = "timeout";
    end else begin
      m_done    = 1'b0;
      m_timeout = 1'b0;
      outcome   = "abort";
    end
    check_regs("txn");
    n_txn++;
    $display("txn %0d: drop=%0d fe=%0d -> %s result=0x%04h seq=%0d",
             n_txn, r, fe, outcome, m_result, m_seq);
  endtask

  initial begin
    logic [31:0] d;
    int r, fe;

    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.read_n     = 1'b1;
    m_result  = '0;
    m_seq     = '0;
    m_done    = 1'b0;
    m_timeout = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_regs("reset");
    check("reset_irq2", {31'b0, irq}, 32'h0);

    // capture 10 cycles after the request
    run_txn(20, 10, 'h2A);
    bus_if.chipselect = 1'b0;
    #1;
    check("cs_low_zero", bus_if.readdata, 32'h0);

    // timeout, abort, edge-coincident pulse, capture on the timeout cycle
    run_txn(T + 4, -1, -1);
    run_txn(8, 20, -1);
    run_txn(12, LAT - 1, -1);
    run_txn(T + 5, T + LAT - 1, 'h0BEE);

    // randomised transactions
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) r = T + int'($urandom_range(0, 5));
      else                           r = int'($urandom_range(1, T + 6));
      if ($urandom_range(0, 3) == 0) fe = -1;
      else                           fe = int'($urandom_range(0, T + 8));
      run_txn(r, fe, -1);
    end

    // reset in the middle of WAIT_EOF, after a capture has been stored
    run_txn(15, 5, 'h1234);
    @(posedge clk); #1;
    req_level = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    bus_read(ADDR_STATUS, d);
    check("pre_reset_busy", d, status_word(1'b0, 1'b1, 1'b0));
    reset_n   = 1'b0;
    req_level = 1'b0;
    #1;
    m_result  = '0;
    m_seq     = '0;
    m_done    = 1'b0;
    m_timeout = 1'b0;
    check("mid_reset_irq", {31'b0, irq}, 32'h0);
    check_regs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_regs("post_reset");

    // 256 handshakes wrap the sequence number back to zero
    for (int i = 0; i < 256; i++) begin
      run_txn(12, 6 + (i % 4), -1);
    end
    bus_read(ADDR_SEQ, d);
    check("seq_wrap", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
